// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one external MSB-first serial comparator between
// N_REQ parallel requesters; returns a tagged less/eq/greater result per transfer.
module serial_compare_scheduler #(
    parameter int W     = 8,
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic                 cmp_clear,
    output logic                 ser_a,
    output logic                 ser_b,
    input  logic                 cmp_less,
    input  logic                 cmp_eq,
    input  logic                 cmp_greater,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_less,
    output logic                 res_eq,
    output logic                 res_greater
);

    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic              res_less_q, res_less_d;
    logic              res_eq_q, res_eq_d;
    logic              res_greater_q, res_greater_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand;
    logic [W-1:0]      sel_a, sel_b;

    // Round-robin search starting just after the last granted requester.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        res_id_d      = res_id_q;
        res_less_d    = res_less_q;
        res_eq_d      = res_eq_q;
        res_greater_d = res_greater_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    a_d          = sel_a;
                    b_d          = sel_b;
                    res_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = CNT_W'(W-1);
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - 1'b1;
                // Comparator flags already include the final bit combinationally.
                if (cnt_q == '0) begin
                    res_less_d    = cmp_less;
                    res_eq_d      = cmp_eq;
                    res_greater_d = cmp_greater;
                    state_d       = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: captured operands are plain registers and are cleared on reset so an aborted transfer leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= ID_W'(N_REQ-1);
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_id_q      <= '0;
            res_less_q    <= 1'b0;
            res_eq_q      <= 1'b0;
            res_greater_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            res_id_q      <= res_id_d;
            res_less_q    <= res_less_d;
            res_eq_q      <= res_eq_d;
            res_greater_q <= res_greater_d;
        end
    end

    assign req_ready   = (state_q == IDLE && grant_found) ? (N_REQ'(1) << grant_idx) : '0;
    assign cmp_clear   = (state_q != SHIFT);
    assign ser_a       = (state_q == SHIFT) && a_q[cnt_q];
    assign ser_b       = (state_q == SHIFT) && b_q[cnt_q];
    assign res_valid   = (state_q == RESULT);
    assign res_id      = res_id_q;
    assign res_less    = res_less_q;
    assign res_eq      = res_eq_q;
    assign res_greater = res_greater_q;

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Scoreboard bench for serial_compare_scheduler: emulated serial comparator,
// transaction-level reference model, directed scenarios then randomized traffic.
module tb_serial_compare_scheduler;

    localparam int W     = 8;
    localparam int N_REQ = 2;
    localparam int ID_W  = $clog2(N_REQ);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*W-1:0]  req_a = '0;
    logic [N_REQ*W-1:0]  req_b = '0;
    logic                cmp_clear, ser_a, ser_b;
    logic                cmp_less, cmp_eq, cmp_greater;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [ID_W-1:0]     res_id;
    logic                res_less, res_eq, res_greater;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            l;
        logic            e;
        logic            g;
    } res_t;

    res_t exp_q[$];

    serial_compare_scheduler #(.W(W), .N_REQ(N_REQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .cmp_clear(cmp_clear), .ser_a(ser_a), .ser_b(ser_b),
        .cmp_less(cmp_less), .cmp_eq(cmp_eq), .cmp_greater(cmp_greater),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater)
    );

    always #5 clk = ~clk;

    // External comparator: 0 = undecided, 1 = A<B, 2 = A>B; first differing bit decides.
    logic [1:0] cst = 2'd0;
    always @(posedge clk) begin
        if (cmp_clear) cst <= 2'd0;
        else if (cst == 2'd0 && ser_a != ser_b) cst <= ser_b ? 2'd1 : 2'd2;
    end
    assign cmp_less    = (cst == 2'd1) || (cst == 2'd0 && !ser_a && ser_b);
    assign cmp_greater = (cst == 2'd2) || (cst == 2'd0 && ser_a && !ser_b);
    assign cmp_eq      = (cst == 2'd0) && (ser_a == ser_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer occupies the block from accept until its result is consumed.
    initial begin : model
        bit               m_known, m_busy, m_post_rst, shifting;
        int               m_k, m_last, g, idx, clr_g;
        logic [W-1:0]     m_a, m_b;
        logic [N_REQ-1:0] exp_ready;
        m_known = 0; m_busy = 0; m_post_rst = 0;
        m_k = 0; m_last = N_REQ-1; m_a = '0; m_b = '0;
        forever begin
            @(negedge clk);
            clr_g = -1;
            g     = -1;
            if (!m_busy) begin
                for (int i = 1; i <= N_REQ; i++) begin
                    idx = (m_last + i) % N_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (m_known) begin
                exp_ready = (g >= 0) ? (N_REQ'(1) << g) : '0;
                shifting  = m_busy && (m_k <= W);
                check("req_ready", req_ready, exp_ready);
                check("cmp_clear", cmp_clear, !shifting);
                check("ser_a", ser_a, shifting ? m_a[W-m_k] : 1'b0);
                check("ser_b", ser_b, shifting ? m_b[W-m_k] : 1'b0);
                check("res_valid", res_valid, m_busy && (m_k > W));
                if (m_post_rst) check("reset_res", {res_id, res_less, res_eq, res_greater}, '0);
            end
            m_post_rst = 0;
            if (!rst) begin
                m_known = 1; m_busy = 0; m_last = N_REQ-1; m_post_rst = 1;
                exp_q.delete();
            end else if (m_known) begin
                if (!m_busy && g >= 0) begin
                    m_a = req_a[g*W +: W];
                    m_b = req_b[g*W +: W];
                    exp_q.push_back(res_t'{ID_W'(g), m_a < m_b, m_a == m_b, m_a > m_b});
                    m_last = g; m_busy = 1; m_k = 1; clr_g = g;
                end else if (m_busy) begin
                    if (m_k > W && res_ready) m_busy = 0;
                    else m_k++;
                end
            end
            if (clr_g >= 0) begin
                @(posedge clk);
                #1 req_valid[clr_g] = 1'b0;
            end
        end
    end

    // Result monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin : monitor
        res_t got;
        forever begin
            @(negedge clk);
            if (rst && res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", res_valid, 1'b0);
                end else begin
                    got = {res_id, res_less, res_eq, res_greater};
                    check("result", got, exp_q[0]);
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_free(input int i);
        for (int c = 0; c < 200 && req_valid[i]; c++) tick();
        check("accept_timeout", req_valid[i], 1'b0);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int c = 0; c < 400 && (req_valid != '0 || exp_q.size() != 0); c++) tick();
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) tick();
    endtask

    initial begin : driver
        logic [W-1:0] ra, rb;
        repeat (3) tick();
        rst = 1'b1;
        res_ready = 1'b1;

        post(0, 8'h64, 8'h62); drain();
        post(1, 8'hA5, 8'hA5); drain();
        post(0, 8'h00, 8'h80); drain();

        // Both requesters continuously valid: grants must alternate.
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i]) post(i, W'($urandom), W'($urandom));
            end
            tick();
        end
        drain();

        // Result back-pressure with a pending second requester.
        res_ready = 1'b0;
        post(0, 8'h12, 8'h34);
        wait_free(0);
        post(1, 8'h56, 8'h56);
        for (int c = 0; c < 50 && !res_valid; c++) tick();
        check("res_valid_timeout", res_valid, 1'b1);
        repeat (5) tick();
        drain();

        // Reset during SHIFT bit 4 aborts the transfer.
        post(0, 8'hF0, 8'h00);
        wait_free(0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        post(0, 8'h3C, 8'h3C);
        post(1, W'($urandom), W'($urandom));
        drain();

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    ra = W'($urandom);
                    rb = ($urandom_range(3) == 0) ? ra : W'($urandom);
                    post(i, ra, rb);
                end
            end
            res_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(150) != 0);
            tick();
        end
        rst = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_compare_scheduler.md
Name: serial_compare_scheduler

Overview:
- Shares one external MSB-first serial comparator FSM between N_REQ requesters.
- Each requester presents a parallel W-bit operand pair with a valid/ready handshake. The scheduler grants one requester round-robin, captures its operands, clears the comparator, and streams the bits MSB first.
- It samples the comparator flags on the last bit and returns a tagged result over a valid/ready handshake.
- Sits between the parallel request side and the serial comparator datapath.

Parameters:
- W, 8: operand width in bits; must be at least 2.
- N_REQ, 2: number of requesters; must be at least 2.
- ID_W, $clog2(N_REQ): width of the requester index.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-low.
- req_valid  input  N_REQ  per-requester operand pair valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit set; one-hot.
- req_a  input  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  input  N_REQ*W  operand B; same packing as req_a.
- cmp_clear  output  1  active-high synchronous clear to the comparator state.
- ser_a  output  1  serial bit of A to the comparator.
- ser_b  output  1  serial bit of B to the comparator.
- cmp_less  input  1  comparator a_less_b; combinational on the current bit and comparator state.
- cmp_eq  input  1  comparator a_eq_b.
- cmp_greater  input  1  comparator a_greater_b.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer accept.
- res_id  output  ID_W  index of the requester the result belongs to.
- res_less  output  1  A < B.
- res_eq  output  1  A == B.
- res_greater  output  1  A > B.

Behaviour:
- Registered FSM states: IDLE, SHIFT, RESULT. A bit counter runs W-1 down to 0. A round-robin pointer holds last_grant.
- Reset (rst low at a clock edge):
  - state = IDLE, last_grant = N_REQ-1, so requester 0 has first priority.
  - res_valid = 0; res_id, res_less, res_eq, res_greater all 0; captured operands cleared.
  - Reset mid-operation aborts the transfer. No result is produced and no partial state survives.
- Outputs decoded from state:
  - cmp_clear = 1 in IDLE and RESULT, 0 in SHIFT.
  - ser_a and ser_b = 0 outside SHIFT.
  - req_ready = 0 outside IDLE.
  - Consequence: the comparator is always cleared on the edge that accepts a request.
- IDLE:
  - If any req_valid is set, req_ready is one-hot on the first valid index searching last_grant+1, last_grant+2, ... with wrap.
  - A handshake on bit g captures req_a/req_b slice g and g into res_id; sets last_grant = g and counter = W-1; moves to SHIFT.
  - If no req_valid is set, req_ready = 0 and the FSM stays in IDLE.
- SHIFT:
  - ser_a and ser_b = captured A[counter] and B[counter].
  - The counter decrements every cycle.
  - On the cycle counter == 0: capture cmp_less, cmp_eq and cmp_greater into res_*, then go to RESULT.
  - Exactly W SHIFT cycles per transfer.
- RESULT:
  - res_valid = 1; res_* and res_id held stable until res_valid && res_ready, then go to IDLE.
  - A handshake in the first RESULT cycle is legal.
  - No new request is accepted until the FSM is back in IDLE.
- Latency: accept edge ends cycle T; SHIFT occupies T+1..T+W; res_valid is asserted from cycle T+W+1.
  - Minimum issue interval is W+2 cycles with res_ready held high.
- Captured operands are private. Requesters may change or drop req_a/req_b/req_valid after their handshake without effect.
- Only the granted requester's handshake counts. Validity of ungranted requesters is ignored that cycle; they keep waiting, with no starvation guarantee violated.
- Exactly one of res_less/res_eq/res_greater is expected from the comparator. The scheduler passes the flags through unmodified and does not check them.

Test Plan:
- W=8. Req0 sends a=0x64, b=0x62, res_ready=1.
  - ser_a sequence 0,1,1,0,0,1,0,0; ser_b sequence 0,1,1,0,0,0,1,0.
  - cmp_clear low exactly 8 cycles.
  - res_valid 9 cycles after the accept cycle with res_greater=1, res_id=0.
- Req1 sends a=b=0xA5 -> res_eq=1, res_less=0, res_greater=0, res_id=1.
- Req0 sends a=0x00, b=0x80 -> res_less=1. The first SHIFT cycle drives ser_a=0, ser_b=1.
- Req0 and req1 both valid continuously with res_ready=1 -> grants alternate 0,1,0,1. Each accept is spaced 10 cycles apart, and res_id matches the grant order.
- res_ready low for 5 cycles after res_valid:
  - res_valid, res_id and res_* stay stable.
  - req_ready stays 0 despite a pending req1.
  - On the handshake, the next cycle is IDLE and req1 is granted.
- Start a=0xF0, b=0x00; drop rst for 1 cycle during SHIFT bit 4. The next cycle is IDLE with res_valid=0 and cmp_clear=1. A following request a=b=0x3C returns res_eq=1, and req0 again has first priority.
